// File: rtl/ide_pkg.sv
// Shared definitions for the Gayle-compatible IDE PIO engine: FSM encoding,
// address decode constants and 68020 DSACK termination codes.
package ide_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_ACK,
        ST_RECOVER
    } ide_state_e;

    // A[23:15] of the $DA0000 IDE window
    localparam logic [8:0] GAYLE_IDE_BASE = 9'h1B4;

    localparam int PORT_LSB   = 13;
    localparam int PORT_W     = 2;
    localparam int CS_SEL_BIT = 12;

    // 68020 dynamic bus sizing: DSACK1 low, DSACK0 high terminates as 16-bit
    localparam logic [1:0] DSACK16    = 2'b01;
    localparam logic [1:0] DSACK_IDLE = 2'b11;

    function automatic logic [PORT_W-1:0] port_idx(input logic [23:0] addr);
        return addr[PORT_LSB +: PORT_W];
    endfunction

endpackage

// File: rtl/ide_pio_engine_if.sv
// CPU-side bus and IDE-side strobes of the PIO engine; the engine is the
// slave of the 68020 bus and the owner of the IDE strobes.
interface ide_pio_engine_if #(
    parameter int NCHAN = 2
);
    logic [23:0]        A;
    logic               AS20;
    logic               RW20;
    logic               HIT;
    logic [2*NCHAN-1:0] IDECS;
    logic               IOR;
    logic               IOW;
    logic [1:0]         DSACK;
    logic               BUSY;

    modport slave (
        input  A, AS20, RW20,
        output HIT, IDECS, IOR, IOW, DSACK, BUSY
    );

    modport master (
        output A, AS20, RW20,
        input  HIT, IDECS, IOR, IOW, DSACK, BUSY
    );

endinterface

// File: rtl/ide_int_sync.sv
// Two-flop synchroniser for the asynchronous per-port IDE interrupts,
// masked and OR-reduced onto a single request line.
module ide_int_sync #(
    parameter int               NCHAN    = 2,
    parameter logic [NCHAN-1:0] INT_MASK = {NCHAN{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCHAN-1:0] irq_raw,
    output logic             irq_out
);

    logic [NCHAN-1:0] meta_q, meta_d;
    logic [NCHAN-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = irq_raw;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    // Level-sensitive: the request follows the source, nothing is latched
    assign irq_out = |(sync_q & INT_MASK);

endmodule

// File: rtl/ide_pio_engine.sv
// Multi-port Gayle-style IDE PIO engine: decodes the $DA0000 window and runs
// a timed setup/strobe/acknowledge/recovery cycle with 16-bit DSACK.
module ide_pio_engine
    import ide_pkg::*;
#(
    parameter int               NCHAN     = 2,
    parameter int               T_SETUP   = 1,
    parameter int               T_ACTIVE  = 4,
    parameter int               T_RECOVER = 2,
    parameter logic [NCHAN-1:0] INT_MASK  = {NCHAN{1'b1}}
) (
    input  logic                CLKCPU,
    input  logic                RESET,
    ide_pio_engine_if.slave     bus,
    input  logic [NCHAN-1:0]    IDEINT,
    output logic                INT2
);

    localparam logic [3:0] SETUP_LOAD   = 4'(T_SETUP - 1);
    localparam logic [3:0] ACTIVE_LOAD  = 4'(T_ACTIVE - 1);
    localparam logic [3:0] RECOVER_LOAD = 4'(T_RECOVER - 1);

    ide_state_e         state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [PORT_W-1:0]  port_q, port_d;
    logic               cs_sel_q, cs_sel_d;
    logic               rw_q, rw_d;
    logic [2*NCHAN-1:0] idecs_q, idecs_d;
    logic               ior_q, ior_d;
    logic               iow_q, iow_d;
    logic [1:0]         dsack_q, dsack_d;

    logic hit;
    logic end_cycle;
    logic cs_on, strobe_on, ack_on;
    logic unused_addr;

    assign hit = (bus.A[23:15] == GAYLE_IDE_BASE)
              && (int'(port_idx(bus.A)) < NCHAN)
              && !bus.AS20;

    assign unused_addr = ^bus.A[11:0];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        cnt_d     = cnt_q;
        port_d    = port_q;
        cs_sel_d  = cs_sel_q;
        rw_d      = rw_q;
        end_cycle = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    port_d   = port_idx(bus.A);
                    cs_sel_d = bus.A[CS_SEL_BIT];
                    rw_d     = bus.RW20;
                    if (T_SETUP == 0) begin
                        state_d = ST_STROBE;
                        cnt_d   = ACTIVE_LOAD;
                    end else begin
                        state_d = ST_SETUP;
                        cnt_d   = SETUP_LOAD;
                    end
                end
            end
            ST_SETUP: begin
                if (bus.AS20) begin
                    end_cycle = 1'b1;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_STROBE;
                    cnt_d   = ACTIVE_LOAD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_STROBE: begin
                if (bus.AS20) begin
                    end_cycle = 1'b1;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACK: begin
                if (bus.AS20) begin
                    end_cycle = 1'b1;
                end
            end
            ST_RECOVER: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Normal completion and abort share the same exit path
        if (end_cycle) begin
            if (T_RECOVER == 0) begin
                state_d = ST_IDLE;
            end else begin
                state_d = ST_RECOVER;
                cnt_d   = RECOVER_LOAD;
            end
        end
    end

    // Outputs follow the current state one clock later, except that the
    // edge sampling AS20 high releases everything immediately.
    always_comb begin
        cs_on     = 1'b0;
        strobe_on = 1'b0;
        ack_on    = 1'b0;
        if (!end_cycle) begin
            case (state_q)
                ST_SETUP:  cs_on = 1'b1;
                ST_STROBE: begin
                    cs_on     = 1'b1;
                    strobe_on = 1'b1;
                end
                ST_ACK: begin
                    cs_on     = 1'b1;
                    strobe_on = 1'b1;
                    ack_on    = 1'b1;
                end
                default: ;
            endcase
        end

        for (int k = 0; k < 2*NCHAN; k++) begin
            idecs_d[k] = !(cs_on && (int'({port_q, cs_sel_q}) == k));
        end
        ior_d   = !(strobe_on && rw_q);
        iow_d   = !(strobe_on && !rw_q);
        dsack_d = ack_on ? DSACK16 : DSACK_IDLE;
    end

    always_ff @(posedge CLKCPU or negedge RESET) begin
        if (!RESET) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            port_q   <= '0;
            cs_sel_q <= 1'b0;
            rw_q     <= 1'b0;
            idecs_q  <= '1;
            ior_q    <= 1'b1;
            iow_q    <= 1'b1;
            dsack_q  <= DSACK_IDLE;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            port_q   <= port_d;
            cs_sel_q <= cs_sel_d;
            rw_q     <= rw_d;
            idecs_q  <= idecs_d;
            ior_q    <= ior_d;
            iow_q    <= iow_d;
            dsack_q  <= dsack_d;
        end
    end

    assign bus.HIT   = hit;
    assign bus.IDECS = idecs_q;
    assign bus.IOR   = ior_q;
    assign bus.IOW   = iow_q;
    assign bus.DSACK = dsack_q;
    assign bus.BUSY  = (state_q != ST_IDLE);

    ide_int_sync #(
        .NCHAN    (NCHAN),
        .INT_MASK (INT_MASK)
    ) u_int_sync (
        .clk     (CLKCPU),
        .rst_n   (RESET),
        .irq_raw (IDEINT),
        .irq_out (INT2)
    );

endmodule

// File: tb/tb_ide_pio_engine.sv
// Directed bench for ide_pio_engine: default timing, a fast-timing variant
// and a masked-interrupt variant, all driven from one clock and reset.
module tb_ide_pio_engine;

    logic       clk;
    logic       rst_n;
    logic [1:0] ideint_a, ideint_b, ideint_c;
    logic       int2_a, int2_b, int2_c;

    int n_checks = 0;
    int n_errors = 0;

    ide_pio_engine_if #(.NCHAN(2)) bus_a ();
    ide_pio_engine_if #(.NCHAN(2)) bus_b ();
    ide_pio_engine_if #(.NCHAN(2)) bus_c ();

    ide_pio_engine #(.NCHAN(2)) u_dut_a (
        .CLKCPU (clk),
        .RESET  (rst_n),
        .bus    (bus_a),
        .IDEINT (ideint_a),
        .INT2   (int2_a)
    );

    ide_pio_engine #(.NCHAN(2), .T_SETUP(0), .T_ACTIVE(1), .T_RECOVER(0)) u_dut_b (
        .CLKCPU (clk),
        .RESET  (rst_n),
        .bus    (bus_b),
        .IDEINT (ideint_b),
        .INT2   (int2_b)
    );

    ide_pio_engine #(.NCHAN(2), .INT_MASK(2'b10)) u_dut_c (
        .CLKCPU (clk),
        .RESET  (rst_n),
        .bus    (bus_c),
        .IDEINT (ideint_c),
        .INT2   (int2_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        ideint_a = 2'b00;
        ideint_b = 2'b00;
        ideint_c = 2'b00;
        bus_a.A = 24'h0; bus_a.AS20 = 1'b1; bus_a.RW20 = 1'b1;
        bus_b.A = 24'h0; bus_b.AS20 = 1'b1; bus_b.RW20 = 1'b1;
        bus_c.A = 24'h0; bus_c.AS20 = 1'b1; bus_c.RW20 = 1'b1;

        tick();
        tick();
        check("rst_cs",    bus_a.IDECS, 4'b1111);
        check("rst_ior",   bus_a.IOR,   1'b1);
        check("rst_iow",   bus_a.IOW,   1'b1);
        check("rst_dsack", bus_a.DSACK, 2'b11);
        check("rst_busy",  bus_a.BUSY,  1'b0);
        check("rst_int2",  int2_c,      1'b0);
        rst_n = 1'b1;
        tick();

        // Read, port 0 CS0: accept at edge 0, AS20 sampled high at edge 8
        bus_a.A = 24'hDA0000; bus_a.RW20 = 1'b1; bus_a.AS20 = 1'b0;
        #1 check("rd_hit", bus_a.HIT, 1'b1);
        for (int e = 0; e <= 10; e++) begin
            if (e == 8) bus_a.AS20 = 1'b1;
            tick();
            check($sformatf("rd_cs_e%0d", e),    bus_a.IDECS, (e >= 1 && e <= 7) ? 4'b1110 : 4'b1111);
            check($sformatf("rd_ior_e%0d", e),   bus_a.IOR,   (e >= 2 && e <= 7) ? 1'b0 : 1'b1);
            check($sformatf("rd_iow_e%0d", e),   bus_a.IOW,   1'b1);
            check($sformatf("rd_dsack_e%0d", e), bus_a.DSACK, (e == 6 || e == 7) ? 2'b01 : 2'b11);
            check($sformatf("rd_busy_e%0d", e),  bus_a.BUSY,  (e <= 9) ? 1'b1 : 1'b0);
        end

        // Write, port 1 CS1
        bus_a.A = 24'hDA3000; bus_a.RW20 = 1'b0; bus_a.AS20 = 1'b0;
        for (int e = 0; e <= 10; e++) begin
            if (e == 8) bus_a.AS20 = 1'b1;
            tick();
            check($sformatf("wr_cs_e%0d", e),    bus_a.IDECS, (e >= 1 && e <= 7) ? 4'b0111 : 4'b1111);
            check($sformatf("wr_iow_e%0d", e),   bus_a.IOW,   (e >= 2 && e <= 7) ? 1'b0 : 1'b1);
            check($sformatf("wr_ior_e%0d", e),   bus_a.IOR,   1'b1);
            check($sformatf("wr_dsack_e%0d", e), bus_a.DSACK, (e == 6 || e == 7) ? 2'b01 : 2'b11);
        end

        // Abort: AS20 rises after edge 3, drops again after edge 5
        bus_a.A = 24'hDA0000; bus_a.RW20 = 1'b1; bus_a.AS20 = 1'b0;
        for (int e = 0; e <= 8; e++) begin
            if (e == 4) bus_a.AS20 = 1'b1;
            if (e == 6) bus_a.AS20 = 1'b0;
            tick();
            check($sformatf("ab_cs_e%0d", e),    bus_a.IDECS,
                  ((e >= 1 && e <= 3) || e == 8) ? 4'b1110 : 4'b1111);
            check($sformatf("ab_ior_e%0d", e),   bus_a.IOR,   (e == 2 || e == 3) ? 1'b0 : 1'b1);
            check($sformatf("ab_dsack_e%0d", e), bus_a.DSACK, 2'b11);
            check($sformatf("ab_busy_e%0d", e),  bus_a.BUSY,  (e == 6) ? 1'b0 : 1'b1);
        end
        bus_a.AS20 = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("ab_idle", bus_a.BUSY, 1'b0);

        // Decode misses
        bus_a.A = 24'hDA6000; bus_a.AS20 = 1'b0;
        #1 check("miss_port_hit", bus_a.HIT, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        check("miss_port_busy",  bus_a.BUSY,  1'b0);
        check("miss_port_ior",   bus_a.IOR,   1'b1);
        check("miss_port_cs",    bus_a.IDECS, 4'b1111);
        check("miss_port_dsack", bus_a.DSACK, 2'b11);
        bus_a.A = 24'hDA8000;
        #1 check("miss_a15_hit", bus_a.HIT, 1'b0);
        tick();
        check("miss_a15_busy", bus_a.BUSY, 1'b0);
        bus_a.AS20 = 1'b1;
        bus_a.A = 24'hDA0000;
        #1 check("as_high_hit", bus_a.HIT, 1'b0);
        tick();

        // Fast timing: T_SETUP=0, T_ACTIVE=1, T_RECOVER=0
        bus_b.A = 24'hDA0000; bus_b.RW20 = 1'b1; bus_b.AS20 = 1'b0;
        for (int e = 0; e <= 6; e++) begin
            if (e == 3) bus_b.AS20 = 1'b1;
            if (e == 4) bus_b.AS20 = 1'b0;
            if (e == 6) bus_b.AS20 = 1'b1;
            tick();
            check($sformatf("fast_cs_e%0d", e),    bus_b.IDECS,
                  (e == 1 || e == 2 || e == 5) ? 4'b1110 : 4'b1111);
            check($sformatf("fast_ior_e%0d", e),   bus_b.IOR,
                  (e == 1 || e == 2 || e == 5) ? 1'b0 : 1'b1);
            check($sformatf("fast_dsack_e%0d", e), bus_b.DSACK, (e == 2) ? 2'b01 : 2'b11);
            check($sformatf("fast_busy_e%0d", e),  bus_b.BUSY,  (e == 3 || e == 6) ? 1'b0 : 1'b1);
        end

        // Interrupts: u_dut_c masks port 0, u_dut_a enables both
        ideint_c = 2'b01;
        ideint_a = 2'b01;
        tick();
        check("int_a_1edge", int2_a, 1'b0);
        tick();
        check("int_a_2edge", int2_a, 1'b1);
        tick();
        check("int_c_masked", int2_c, 1'b0);
        ideint_a = 2'b00;
        ideint_c = 2'b10;
        tick();
        check("int_c_1edge", int2_c, 1'b0);
        tick();
        check("int_c_2edge", int2_c, 1'b1);
        ideint_c = 2'b00;
        tick();
        check("int_c_fall_1edge", int2_c, 1'b1);
        tick();
        check("int_c_fall_2edge", int2_c, 1'b0);

        // Reset mid-cycle and with an interrupt pending
        ideint_c = 2'b10;
        bus_a.A = 24'hDA0000; bus_a.RW20 = 1'b1; bus_a.AS20 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("pre_rst_ior",  bus_a.IOR, 1'b0);
        check("pre_rst_int2", int2_c,    1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ior",   bus_a.IOR,   1'b1);
        check("mid_rst_cs",    bus_a.IDECS, 4'b1111);
        check("mid_rst_dsack", bus_a.DSACK, 2'b11);
        check("mid_rst_busy",  bus_a.BUSY,  1'b0);
        check("mid_rst_int2",  int2_c,      1'b0);
        bus_a.AS20 = 1'b1;
        ideint_c   = 2'b00;
        tick();
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
